// File: rtl/cs161_mem_responder.sv
// Word-organised data memory that answers valid/ready load/store requests after a fixed number of wait states.
// Optional build macro: MEM_RESP_ERR_CHECK_EN adds misalignment and out-of-range rejection.
`timescale 1ns/1ps

module cs161_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    // Handshake rules: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where resp_valid && resp_ready. Neither ready
    // nor valid depends combinationally on any input.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [DEPTH];

    logic                  acc_write;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_err;
    logic                  acc_en;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    // With zero wait states the access happens on the acceptance edge, so it uses the live request.
    always_comb begin
        acc_write = lat_write;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == S_IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign acc_idx = acc_addr[ADDR_WIDTH+1:2];
    assign acc_en  = ((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd1));

`ifdef MEM_RESP_ERR_CHECK_EN
    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_WIDTH+2] != '0);
`else
    logic unused_addr_bits;
    assign acc_err          = 1'b0;
    assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[31:ADDR_WIDTH+2]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (acc_en) begin
                if (acc_write && !acc_err) begin
                    mem[acc_idx] <= acc_wdata;
                end
                resp_rdata <= (acc_write || acc_err) ? 32'h0 : mem[acc_idx];
                resp_err   <= acc_err;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= WAIT_LD;
                        state     <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cs161_mem_responder.sv
// Directed bench for cs161_mem_responder: a vector table run on a 2-wait-state instance,
// plus hand-written reset-in-WAIT and zero-wait-state back-to-back sequences.
`timescale 1ns/1ps

module tb_cs161_mem_responder;
`ifdef MEM_RESP_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_resp_ready = 1'b0;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic        z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    cs161_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    cs161_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rdata;
        bit          exp_err;
        string       name;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction on the 2-wait instance. While the request is in flight the
    // request inputs carry a junk store to the neighbouring word, which must be ignored.
    task automatic do_access(input vec_t v);
        int          lat;
        logic [31:0] first_rdata;
        logic        first_err;
        @(negedge clk);
        check({v.name, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_write = 1'b1;
        req_addr  = v.addr ^ 32'h4;
        req_wdata = 32'hFFFF_FFFF;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (resp_valid) break;
            check({v.name, "_ready_busy"}, 32'(req_ready), 32'd0);
        end
        check({v.name, "_latency"}, 32'(lat), 32'(W));
        first_rdata = resp_rdata;
        first_err   = resp_err;
        check({v.name, "_rdata"}, first_rdata, v.exp_rdata);
        check({v.name, "_err"}, 32'(first_err), 32'(v.exp_err));
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk);
            #1;
            check({v.name, "_bp_valid"}, 32'(resp_valid), 32'd1);
            check({v.name, "_bp_rdata"}, resp_rdata, v.exp_rdata);
            check({v.name, "_bp_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({v.name, "_hs_valid"}, 32'(resp_valid), 32'd0);
        check({v.name, "_hs_ready"}, 32'(req_ready), 32'd1);
        check({v.name, "_hs_rdata"}, resp_rdata, 32'h0);
        check({v.name, "_hs_err"}, 32'(resp_err), 32'd0);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        1'b0, "st_10"};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0, "ld_10"};
        vecs[2]  = '{1'b0, 32'h10,  32'h0,        5, 32'hDEADBEEF, 1'b0, "ld_10_bp"};
        vecs[3]  = '{1'b1, 32'h00,  32'hA5A5A5A5, 0, 32'h0,        1'b0, "st_00"};
        vecs[4]  = '{1'b1, 32'h3FC, 32'h0BADF00D, 1, 32'h0,        1'b0, "st_top"};
        vecs[5]  = '{1'b0, 32'h3FC, 32'h0,        0, 32'h0BADF00D, 1'b0, "ld_top"};
        vecs[6]  = '{1'b0, 32'h14,  32'h0,        0, 32'h0,        1'b0, "ld_14_clean"};
        vecs[7]  = '{1'b1, 32'h11,  32'h12345678, 0, 32'h0,        ERR_EN, "st_misal"};
        vecs[8]  = '{1'b0, 32'h10,  32'h0,        0, ERR_EN ? 32'hDEADBEEF : 32'h12345678, 1'b0, "ld_after_misal"};
        vecs[9]  = '{1'b0, 32'h400, 32'h0,        0, ERR_EN ? 32'h0 : 32'hA5A5A5A5, ERR_EN, "ld_oor"};
        vecs[10] = '{1'b0, 32'h7FC, 32'h0,        2, ERR_EN ? 32'h0 : 32'h0BADF00D, ERR_EN, "ld_wrap_top"};

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_access(vecs[i]);
        end

        // Reset during WAIT of a store: the store must not land and no response appears.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("wait_state_valid", 32'(resp_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_valid", 32'(resp_valid), 32'd0);
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("post_rst_no_resp", 32'(seen), 32'd0);
        do_access('{1'b0, 32'h20, 32'h0, 0, 32'h0, 1'b0, "ld_20_after_rst"});
        do_access('{1'b0, 32'h10, 32'h0, 0, 32'h0, 1'b0, "ld_10_cleared"});

        // Zero wait states: response the cycle after acceptance, back-to-back with resp_ready held.
        @(negedge clk);
        z_resp_ready = 1'b1;
        z_req_valid  = 1'b1;
        z_req_write  = 1'b1;
        z_req_addr   = 32'h8;
        z_req_wdata  = 32'h13579BDF;
        @(posedge clk);
        #1;
        z_req_write = 1'b0;
        check("z_st_valid", 32'(z_resp_valid), 32'd1);
        check("z_st_ready", 32'(z_req_ready), 32'd0);
        check("z_st_rdata", z_resp_rdata, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("z_hs_valid", 32'(z_resp_valid), 32'd0);
            check("z_hs_ready", 32'(z_req_ready), 32'd1);
            @(posedge clk);
            #1;
            check("z_ld_valid", 32'(z_resp_valid), 32'd1);
            check("z_ld_rdata", z_resp_rdata, 32'h13579BDF);
            check("z_ld_err", 32'(z_resp_err), 32'd0);
        end
        z_req_valid = 1'b0;
        @(posedge clk);
        #1;
        z_resp_ready = 1'b0;
        check("z_final_idle", 32'(z_req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
